// File: rtl/mbo_uart_pkg.sv
// ====================================================================
// Package : mbo_uart_pkg - shared UART command-path encodings
// Revision: 1.0
// ====================================================================
`default_nettype none

package mbo_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam int FRAME_BYTES = 4;

    localparam logic [1:0] IDX_CTRL = 2'd0;
    localparam logic [1:0] IDX_ADDR = 2'd1;
    localparam logic [1:0] IDX_DHI  = 2'd2;
    localparam logic [1:0] IDX_DLO  = 2'd3;

    localparam int CTRL_WR_BIT = 0;

endpackage

`default_nettype wire

// File: rtl/uart_timeout_cnt.sv
// ====================================================================
// Module  : uart_timeout_cnt - saturating idle counter, expire pulse
// Revision: 1.0
// ====================================================================
`default_nettype none

module uart_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 7440
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the idle cycle that would take the count past its last legal value
    assign expire = en && !clr && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_cmd_framer.sv
// ====================================================================
// Module  : uart_cmd_framer - 4-byte UART frame to valid/ready command
// Revision: 1.0
// ====================================================================
`default_nettype none

module uart_cmd_framer
    import mbo_uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 7440,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_dv,
    input  logic [7:0]           rx_byte,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 cmd_wr,
    output logic [7:0]           cmd_addr,
    output logic [15:0]          cmd_data,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 busy
);

    state_t                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [7:0]             ctrl_q, ctrl_d;
    logic [7:0]             addr_q, addr_d;
    logic [7:0]             dhi_q, dhi_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic                   cmd_wr_q, cmd_wr_d;
    logic [7:0]             cmd_addr_q, cmd_addr_d;
    logic [15:0]            cmd_data_q, cmd_data_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   busy_q, busy_d;

    logic                   to_en;
    logic                   to_expire;

    // Counts only idle COLLECT cycles; any byte or other state restarts it
    assign to_en = (state_q == ST_COLLECT) && !rx_dv;

    uart_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (!to_en),
        .en     (to_en),
        .expire (to_expire)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ctrl_d      = ctrl_q;
        addr_d      = addr_q;
        dhi_d       = dhi_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        err_cnt_d   = err_cnt_q;

        if ((frame_err_q || overrun_q) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_dv) begin
                    ctrl_d  = rx_byte;
                    idx_d   = IDX_ADDR;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (rx_dv) begin
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        IDX_ADDR: addr_d = rx_byte;
                        IDX_DHI:  dhi_d  = rx_byte;
                        IDX_DLO: begin
                            idx_d = IDX_CTRL;
                            if (ctrl_q[7:1] == 7'd0) begin
                                cmd_wr_d   = ctrl_q[CTRL_WR_BIT];
                                cmd_addr_d = addr_q;
                                cmd_data_d = {dhi_q, rx_byte};
                                state_d    = ST_HOLD;
                            end else begin
                                frame_err_d = 1'b1;
                                state_d     = ST_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end else if (to_expire) begin
                    frame_err_d = 1'b1;
                    idx_d       = IDX_CTRL;
                    state_d     = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cmd_ready) begin
                    if (rx_dv) begin
                        ctrl_d  = rx_byte;
                        idx_d   = IDX_ADDR;
                        state_d = ST_COLLECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (rx_dv) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                idx_d   = IDX_CTRL;
                state_d = ST_IDLE;
            end
        endcase

        // Flag outputs are decoded from the next state so they stay registered
        cmd_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= IDX_CTRL;
            ctrl_q      <= '0;
            addr_q      <= '0;
            dhi_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            err_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ctrl_q      <= ctrl_d;
            addr_q      <= addr_d;
            dhi_q       <= dhi_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            err_cnt_q   <= err_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_wr    = cmd_wr_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_data  = cmd_data_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_framer.sv
// ====================================================================
// Module  : tb_uart_cmd_framer - directed + random bench with frame model
// Revision: 1.0
// ====================================================================
`default_nettype none

module tb_uart_cmd_framer;

    localparam int TO   = 24;
    localparam int ECW  = 8;
    localparam int MAXC = (1 << ECW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           rx_dv = 1'b0;
    logic [7:0]     rx_byte = 8'h00;
    logic           cmd_ready = 1'b0;
    logic           cmd_valid;
    logic           cmd_wr;
    logic [7:0]     cmd_addr;
    logic [15:0]    cmd_data;
    logic           frame_err;
    logic           overrun;
    logic [ECW-1:0] err_cnt;
    logic           busy;

    uart_cmd_framer #(
        .TIMEOUT_CYCLES (TO),
        .ERR_CNT_W      (ECW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: bytes of the frame in progress, a HOLD flag, idle gap length
    logic [7:0]  frame[$];
    logic [7:0]  c0;
    bit          holding  = 1'b0;
    int          idle_cnt = 0;
    bit          started  = 1'b0;
    bit          e_valid, e_wr, e_ferr, e_ovr, e_busy;
    logic [7:0]  e_addr;
    logic [15:0] e_data;
    int          e_cnt;
    logic [24:0] got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_cmd(input string name, input logic [24:0] exp);
        logic [24:0] act;
        act = 'x;
        if (got.size() != 0) act = got.pop_front();
        chk(name, {7'd0, act}, {7'd0, exp});
    endtask

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst && cmd_valid === 1'b1 && cmd_ready)
            got.push_back({cmd_wr, cmd_addr, cmd_data});
        if (rst) begin
            frame.delete();
            holding = 1'b0; idle_cnt = 0;
            e_valid = 1'b0; e_wr = 1'b0; e_addr = '0; e_data = '0;
            e_ferr = 1'b0; e_ovr = 1'b0; e_cnt = 0; e_busy = 1'b0;
        end else begin
            if ((e_ferr || e_ovr) && e_cnt < MAXC) e_cnt++;
            e_ferr = 1'b0;
            e_ovr  = 1'b0;
            if (holding) begin
                if (cmd_ready) begin
                    holding = 1'b0;
                    if (rx_dv) begin
                        frame.push_back(rx_byte);
                        idle_cnt = 0;
                    end
                end else if (rx_dv) begin
                    e_ovr = 1'b1;
                end
            end else if (rx_dv) begin
                frame.push_back(rx_byte);
                idle_cnt = 0;
                if (frame.size() == 4) begin
                    c0 = frame[0];
                    if (c0 <= 8'h01) begin
                        holding = 1'b1;
                        e_wr    = c0[0];
                        e_addr  = frame[1];
                        e_data  = {frame[2], frame[3]};
                    end else begin
                        e_ferr = 1'b1;
                    end
                    frame.delete();
                end
            end else if (frame.size() != 0) begin
                idle_cnt++;
                if (idle_cnt == TO) begin
                    e_ferr = 1'b1;
                    frame.delete();
                end
            end
            e_valid = holding;
            e_busy  = holding || (frame.size() != 0);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, e_valid});
            chk("frame_err", {31'd0, frame_err}, {31'd0, e_ferr});
            chk("overrun",   {31'd0, overrun},   {31'd0, e_ovr});
            chk("busy",      {31'd0, busy},      {31'd0, e_busy});
            chk("err_cnt",   {24'd0, err_cnt},   e_cnt);
            if (e_valid) begin
                chk("cmd_wr",   {31'd0, cmd_wr},   {31'd0, e_wr});
                chk("cmd_addr", {24'd0, cmd_addr}, {24'd0, e_addr});
                chk("cmd_data", {16'd0, cmd_data}, {16'd0, e_data});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        rx_dv = 1'b0;
        wait_n(2);
        rst   = 1'b0;
        got.delete();
    endtask

    initial begin
        wait_n(1);
        do_reset();
        chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_addr",  {24'd0, cmd_addr},  32'd0);
        chk("rst_data",  {16'd0, cmd_data},  32'd0);
        chk("rst_cnt",   {24'd0, err_cnt},   32'd0);

        // Valid write, ready held high
        cmd_ready = 1'b1;
        send(8'h01); send(8'h10); send(8'hAB); send(8'hCD);
        wait_n(3);
        exp_cmd("wr_cmd", {1'b1, 8'h10, 16'hABCD});
        chk("wr_cnt", {24'd0, err_cnt}, 32'd0);
        chk("wr_model_cnt", e_cnt, 32'd0);

        // Read with 20 cycles of backpressure
        do_reset();
        cmd_ready = 1'b0;
        send(8'h00); send(8'h22); send(8'h00); send(8'h00);
        wait_n(20);
        chk("bp_held", {31'd0, cmd_valid}, 32'd1);
        chk("bp_none", got.size(), 32'd0);
        cmd_ready = 1'b1;
        wait_n(3);
        exp_cmd("bp_cmd", {1'b0, 8'h22, 16'h0000});
        chk("bp_once", got.size(), 32'd0);

        // Inter-byte timeout then a good frame
        do_reset();
        send(8'h01); send(8'h10);
        wait_n(TO + 2);
        chk("to_cnt", {24'd0, err_cnt}, 32'd1);
        chk("to_model_cnt", e_cnt, 32'd1);
        chk("to_none", got.size(), 32'd0);
        send(8'h01); send(8'h05); send(8'h12); send(8'h34);
        wait_n(3);
        exp_cmd("to_next", {1'b1, 8'h05, 16'h1234});

        // Bad ctrl byte
        do_reset();
        send(8'h81); send(8'h10); send(8'h00); send(8'h01);
        wait_n(3);
        chk("bad_cnt", {24'd0, err_cnt}, 32'd1);
        chk("bad_none", got.size(), 32'd0);

        // Overrun in HOLD, then transfer coinciding with the next ctrl byte
        do_reset();
        cmd_ready = 1'b0;
        send(8'h01); send(8'h10); send(8'h00); send(8'h00);
        wait_n(2);
        send(8'h55);
        wait_n(2);
        chk("ovr_cnt", {24'd0, err_cnt}, 32'd1);
        cmd_ready = 1'b1;
        send(8'h01); send(8'h20); send(8'h00); send(8'h07);
        wait_n(3);
        exp_cmd("ovr_first", {1'b1, 8'h10, 16'h0000});
        exp_cmd("ovr_next",  {1'b1, 8'h20, 16'h0007});
        chk("ovr_cnt2", {24'd0, err_cnt}, 32'd1);

        // Reset mid-frame discards content and error history
        do_reset();
        send(8'h81); send(8'h00); send(8'h00); send(8'h00);
        send(8'h01); send(8'h02);
        rst = 1'b1;
        wait_n(1);
        rst = 1'b0;
        chk("mid_busy", {31'd0, busy},    32'd0);
        chk("mid_cnt",  {24'd0, err_cnt}, 32'd0);
        send(8'h01); send(8'h33); send(8'h44); send(8'h55);
        wait_n(3);
        exp_cmd("mid_cmd", {1'b1, 8'h33, 16'h4455});

        // Error counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send(8'h81); send(8'h00); send(8'h00); send(8'h00);
        end
        wait_n(3);
        chk("sat_cnt", {24'd0, err_cnt}, 32'h0000_00FF);
        chk("sat_model_cnt", e_cnt, 32'd255);

        // Randomised traffic with gaps straddling the timeout
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cmd_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 99) == 0) begin
                rx_dv = 1'b0;
                wait_n(TO - 2 + $urandom_range(0, 3));
            end else begin
                rx_dv = $urandom_range(0, 1) == 1;
                case ($urandom_range(0, 3))
                    0:       rx_byte = 8'h00;
                    1:       rx_byte = 8'h01;
                    default: rx_byte = 8'($urandom);
                endcase
                @(negedge clk);
            end
        end
        rx_dv = 1'b0;
        wait_n(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
